// File: rtl/seg_readback_decoder.sv
// Seven-segment readback monitor: debounces the four digit buses, decodes the
// displayed hex value and checks each newly published value for a +1 step.
module seg_readback_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [0:6]  hex0,
  input  logic [0:6]  hex1,
  input  logic [0:6]  hex2,
  input  logic [0:6]  hex3,
  output logic [15:0] value,
  output logic [3:0]  dig_valid,
  output logic [3:0]  dig_blank,
  output logic        seg_err,
  output logic        update,
  output logic        step_chk,
  output logic        step_ok,
  output logic [7:0]  step_err_cnt
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Returns {illegal, blank, valid, nibble}; bus order a..g, active-low.
  function automatic logic [6:0] decode_digit(input logic [0:6] seg);
    case (seg)
      7'b0000001: return {3'b001, 4'd0};
      7'b1001111: return {3'b001, 4'd1};
      7'b0010010: return {3'b001, 4'd2};
      7'b0000110: return {3'b001, 4'd3};
      7'b1001100: return {3'b001, 4'd4};
      7'b0100100: return {3'b001, 4'd5};
      7'b0100000: return {3'b001, 4'd6};
      7'b0001101: return {3'b001, 4'd7};
      7'b0000000: return {3'b001, 4'd8};
      7'b0000100: return {3'b001, 4'd9};
      7'b1111111: return {3'b010, 4'd0};
      default:    return {3'b100, 4'd0};
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : 8'(x + 8'd1);
  endfunction

  logic [27:0] cand_q, cand_d, pub_vec_q, pub_vec_d, s;
  logic [7:0]  cnt_q, cnt_d, step_err_cnt_q, step_err_cnt_d;
  logic        pub_q, pub_d;
  logic [15:0] value_q, value_d, new_value, next_expected;
  logic [3:0]  dig_valid_q, dig_valid_d, dig_blank_q, dig_blank_d;
  logic [3:0]  new_valid, new_blank, new_illegal;
  logic        seg_err_q, seg_err_d, update_q, update_d;
  logic        step_chk_q, step_chk_d, step_ok_q, step_ok_d;
  logic        accept;
  logic [6:0]  dec0, dec1, dec2, dec3;

  always_comb begin
    s    = {hex3, hex2, hex1, hex0};
    dec0 = decode_digit(hex0);
    dec1 = decode_digit(hex1);
    dec2 = decode_digit(hex2);
    dec3 = decode_digit(hex3);
    new_value     = {dec3[3:0], dec2[3:0], dec1[3:0], dec0[3:0]};
    new_valid     = {dec3[4], dec2[4], dec1[4], dec0[4]};
    new_blank     = {dec3[5], dec2[5], dec1[5], dec0[5]};
    new_illegal   = {dec3[6], dec2[6], dec1[6], dec0[6]};
    next_expected = 16'(value_q + 16'd1);

    cand_d         = cand_q;
    cnt_d          = cnt_q;
    pub_d          = pub_q;
    pub_vec_d      = pub_vec_q;
    value_d        = value_q;
    dig_valid_d    = dig_valid_q;
    dig_blank_d    = dig_blank_q;
    seg_err_d      = seg_err_q;
    step_err_cnt_d = step_err_cnt_q;
    update_d       = 1'b0;
    step_chk_d     = 1'b0;
    step_ok_d      = 1'b0;
    accept         = 1'b0;

    if (sample_en) begin
      if (s == cand_q) begin
        cnt_d = (cnt_q >= STABLE) ? STABLE : 8'(cnt_q + 8'd1);
      end else begin
        cand_d = s;
        cnt_d  = 8'd1;
      end
      // A differing sample also counts as a fresh arrival at the threshold when STABLE is 1.
      accept = (cnt_d == STABLE) && ((s != cand_q) || (cnt_q < STABLE));
    end

    if (accept && (!pub_q || (s != pub_vec_q))) begin
      value_d     = new_value;
      dig_valid_d = new_valid;
      dig_blank_d = new_blank;
      seg_err_d   = |new_illegal;
      update_d    = 1'b1;
      pub_d       = 1'b1;
      pub_vec_d   = s;
      if (pub_q && (dig_valid_q == 4'hF) && (new_valid == 4'hF)) begin
        step_chk_d = 1'b1;
        if (new_value == next_expected) step_ok_d = 1'b1;
        else step_err_cnt_d = sat_inc8(step_err_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q         <= '1;
      cnt_q          <= '0;
      pub_q          <= 1'b0;
      pub_vec_q      <= '1;
      value_q        <= '0;
      dig_valid_q    <= '0;
      dig_blank_q    <= '0;
      seg_err_q      <= 1'b0;
      update_q       <= 1'b0;
      step_chk_q     <= 1'b0;
      step_ok_q      <= 1'b0;
      step_err_cnt_q <= '0;
    end else begin
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      pub_q          <= pub_d;
      pub_vec_q      <= pub_vec_d;
      value_q        <= value_d;
      dig_valid_q    <= dig_valid_d;
      dig_blank_q    <= dig_blank_d;
      seg_err_q      <= seg_err_d;
      update_q       <= update_d;
      step_chk_q     <= step_chk_d;
      step_ok_q      <= step_ok_d;
      step_err_cnt_q <= step_err_cnt_d;
    end
  end

  assign value        = value_q;
  assign dig_valid    = dig_valid_q;
  assign dig_blank    = dig_blank_q;
  assign seg_err      = seg_err_q;
  assign update       = update_q;
  assign step_chk     = step_chk_q;
  assign step_ok      = step_ok_q;
  assign step_err_cnt = step_err_cnt_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Bench for seg_readback_decoder: directed table, hand sequences and random
// stimulus, with both STABLE_CYCLES=4 and STABLE_CYCLES=1 instances.
module tb_seg_readback_decoder;

  logic clk = 1'b0;
  logic reset, sample_en;
  logic [0:6] hex0, hex1, hex2, hex3;

  logic [15:0] value4, value1;
  logic [3:0]  valid4, valid1, blank4, blank1;
  logic        err4, err1, upd4, upd1, chk4, chk1, ok4, ok1;
  logic [7:0]  cnt4, cnt1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seg_readback_decoder #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .value(value4), .dig_valid(valid4), .dig_blank(blank4), .seg_err(err4),
    .update(upd4), .step_chk(chk4), .step_ok(ok4), .step_err_cnt(cnt4));

  seg_readback_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .value(value1), .dig_valid(valid1), .dig_blank(blank1), .seg_err(err1),
    .update(upd1), .step_chk(chk1), .step_ok(ok1), .step_err_cnt(cnt1));

  // Codes 0-9 are glyphs, 10 is blank, 11 is an illegal pattern.
  logic [0:6] glyph [12];
  initial begin
    glyph[0] = 7'b0000001; glyph[1] = 7'b1001111; glyph[2]  = 7'b0010010;
    glyph[3] = 7'b0000110; glyph[4] = 7'b1001100; glyph[5]  = 7'b0100100;
    glyph[6] = 7'b0100000; glyph[7] = 7'b0001101; glyph[8]  = 7'b0000000;
    glyph[9] = 7'b0000100; glyph[10] = 7'b1111111; glyph[11] = 7'b1111110;
  end

  // Reference model: run length of identical enabled samples since reset.
  int          nst [2] = '{4, 1};
  int          run [2];
  bit          has_last [2];
  logic [27:0] last_s [2];
  bit          m_pub [2];
  logic [27:0] m_pvec [2];
  logic [15:0] m_value [2];
  logic [3:0]  m_valid [2], m_blank [2];
  bit          m_err [2], m_upd [2], m_chk [2], m_ok [2];
  int          m_cnt [2];

  function automatic logic [35:0] pack(input logic [15:0] v, input logic [3:0] vd,
      input logic [3:0] bl, input bit e, input bit u, input bit c, input bit o, input int n);
    return {v, vd, bl, e, u, c, o, 8'(n)};
  endfunction

  task automatic model_step();
    logic [27:0] sv;
    logic [6:0]  p;
    int nv, nval, nblk, nerr, found;
    sv = {hex3, hex2, hex1, hex0};
    for (int i = 0; i < 2; i++) begin
      m_upd[i] = 0; m_chk[i] = 0; m_ok[i] = 0;
      if (reset) begin
        run[i] = 0; has_last[i] = 0; m_pub[i] = 0;
        m_value[i] = 0; m_valid[i] = 0; m_blank[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      end else if (sample_en) begin
        if (has_last[i] && sv == last_s[i]) run[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
        else run[i] = 1;
        last_s[i] = sv; has_last[i] = 1;
        if (run[i] == nst[i] && (!m_pub[i] || sv != m_pvec[i])) begin
          nv = 0; nval = 0; nblk = 0; nerr = 0;
          for (int k = 0; k < 4; k++) begin
            p = sv[7*k +: 7];
            found = -1;
            for (int g = 0; g < 10; g++) if (glyph[g] == p) found = g;
            if (found >= 0) begin
              nv = nv + found * (1 << (4*k)); nval = nval | (1 << k);
            end else if (p == 7'h7F) nblk = nblk | (1 << k);
            else nerr = 1;
          end
          if (m_pub[i] && m_valid[i] == 4'hF && nval == 15) begin
            m_chk[i] = 1;
            if (nv == (int'(m_value[i]) + 1) % 65536) m_ok[i] = 1;
            else if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
          end
          m_value[i] = 16'(nv); m_valid[i] = 4'(nval); m_blank[i] = 4'(nblk);
          m_err[i] = (nerr != 0); m_upd[i] = 1; m_pub[i] = 1; m_pvec[i] = sv;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [35:0] act4();
    return pack(value4, valid4, blank4, err4, upd4, chk4, ok4, int'(cnt4));
  endfunction
  function automatic logic [35:0] act1();
    return pack(value1, valid1, blank1, err1, upd1, chk1, ok1, int'(cnt1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("model_s4", act4(), pack(m_value[0], m_valid[0], m_blank[0], m_err[0],
          m_upd[0], m_chk[0], m_ok[0], m_cnt[0]));
    check("model_s1", act1(), pack(m_value[1], m_valid[1], m_blank[1], m_err[1],
          m_upd[1], m_chk[1], m_ok[1], m_cnt[1]));
  endtask

  task automatic set_digits(input int a3, input int a2, input int a1, input int a0);
    hex3 = glyph[a3]; hex2 = glyph[a2]; hex1 = glyph[a1]; hex0 = glyph[a0];
  endtask

  typedef struct {
    bit rst; bit en; int d3; int d2; int d1; int d0; int n; logic [35:0] exp;
  } vec_t;

  vec_t tbl [19];
  int   dg [4];

  function automatic vec_t mk(input bit r, input bit e, input int a3, input int a2,
      input int a1, input int a0, input int n, input logic [35:0] x);
    vec_t t;
    t.rst = r; t.en = e; t.d3 = a3; t.d2 = a2; t.d1 = a1; t.d0 = a0; t.n = n; t.exp = x;
    return t;
  endfunction

  initial begin
    reset = 1'b1; sample_en = 1'b1;
    hex0 = 7'h7F; hex1 = 7'h7F; hex2 = 7'h7F; hex3 = 7'h7F;

    tbl[0]  = mk(1, 1, 1, 2, 3, 4, 2,  pack(16'h0000, 4'h0, 4'h0, 0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 1, 1, 2, 3, 4, 3,  pack(16'h0000, 4'h0, 4'h0, 0, 0, 0, 0, 0));
    tbl[2]  = mk(0, 1, 1, 2, 3, 4, 1,  pack(16'h1234, 4'hF, 4'h0, 0, 1, 0, 0, 0));
    tbl[3]  = mk(0, 1, 1, 2, 3, 5, 3,  pack(16'h1234, 4'hF, 4'h0, 0, 0, 0, 0, 0));
    tbl[4]  = mk(0, 1, 1, 2, 3, 5, 1,  pack(16'h1235, 4'hF, 4'h0, 0, 1, 1, 1, 0));
    tbl[5]  = mk(0, 1, 1, 2, 3, 7, 4,  pack(16'h1237, 4'hF, 4'h0, 0, 1, 1, 0, 1));
    tbl[6]  = mk(0, 1, 1, 2, 3, 8, 2,  pack(16'h1237, 4'hF, 4'h0, 0, 0, 0, 0, 1));
    tbl[7]  = mk(0, 1, 1, 2, 3, 7, 4,  pack(16'h1237, 4'hF, 4'h0, 0, 0, 0, 0, 1));
    tbl[8]  = mk(0, 1, 1, 2, 3, 8, 4,  pack(16'h1238, 4'hF, 4'h0, 0, 1, 1, 1, 1));
    tbl[9]  = mk(0, 1, 1, 2, 3, 10, 4, pack(16'h1230, 4'hE, 4'h1, 0, 1, 0, 0, 1));
    tbl[10] = mk(0, 1, 1, 2, 3, 11, 4, pack(16'h1230, 4'hE, 4'h0, 1, 1, 0, 0, 1));
    tbl[11] = mk(0, 1, 1, 2, 3, 4, 2,  pack(16'h1230, 4'hE, 4'h0, 1, 0, 0, 0, 1));
    tbl[12] = mk(0, 0, 1, 2, 3, 4, 10, pack(16'h1230, 4'hE, 4'h0, 1, 0, 0, 0, 1));
    tbl[13] = mk(0, 1, 1, 2, 3, 4, 1,  pack(16'h1230, 4'hE, 4'h0, 1, 0, 0, 0, 1));
    tbl[14] = mk(0, 1, 1, 2, 3, 4, 1,  pack(16'h1234, 4'hF, 4'h0, 0, 1, 0, 0, 1));
    tbl[15] = mk(0, 1, 5, 6, 7, 8, 3,  pack(16'h1234, 4'hF, 4'h0, 0, 0, 0, 0, 1));
    tbl[16] = mk(1, 1, 5, 6, 7, 8, 1,  pack(16'h0000, 4'h0, 4'h0, 0, 0, 0, 0, 0));
    tbl[17] = mk(0, 1, 5, 6, 7, 8, 3,  pack(16'h0000, 4'h0, 4'h0, 0, 0, 0, 0, 0));
    tbl[18] = mk(0, 1, 5, 6, 7, 8, 1,  pack(16'h5678, 4'hF, 4'h0, 0, 1, 0, 0, 0));

    for (int e = 0; e < 19; e++) begin
      reset = tbl[e].rst; sample_en = tbl[e].en;
      set_digits(tbl[e].d3, tbl[e].d2, tbl[e].d1, tbl[e].d0);
      for (int c = 0; c < tbl[e].n; c++) tick();
      check($sformatf("table[%0d]", e), act4(), tbl[e].exp);
    end

    // 300 alternating non-incrementing steps drive the error count into saturation.
    for (int r = 0; r < 300; r++) begin
      if (r % 2 == 0) set_digits(5, 6, 8, 0); else set_digits(5, 6, 7, 8);
      for (int c = 0; c < 4; c++) tick();
    end
    check("err_saturate", {28'h0, cnt4}, {28'h0, 8'd255});
    check("last_bad_step", {34'h0, chk4, ok4}, {34'h0, 2'b10});

    // STABLE_CYCLES=1 instance publishes on the first differing sample.
    set_digits(9, 9, 9, 9);
    tick();
    check("s1_first_sample", {19'h0, upd1, value1}, {19'h0, 1'b1, 16'h9999});
    check("s4_not_yet", {35'h0, upd4}, 36'h0);
    tick();
    check("s1_hold_no_update", {35'h0, upd1}, 36'h0);
    set_digits(0, 0, 0, 0);
    tick();
    set_digits(0, 0, 0, 1);
    tick();
    check("s1_step_ok", {16'h0, value1, 1'b0, upd1, chk1, ok1}, {16'h0, 16'h0001, 4'b0111});

    // Randomized traffic, checked against the model every cycle.
    for (int k = 0; k < 4; k++) dg[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(99) == 0);
      sample_en = ($urandom_range(99) < 85);
      if ($urandom_range(9) < 2) dg[$urandom_range(3)] = $urandom_range(11);
      else if ($urandom_range(19) == 0) begin
        for (int k = 0; k < 4; k++) if (dg[k] > 9) dg[k] = 0;
        if (dg[0] < 9) dg[0] = dg[0] + 1;
      end
      set_digits(dg[3], dg[2], dg[1], dg[0]);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_readback_decoder.md
Name: seg_readback_decoder

Overview:
Reads back the four 7-segment digit buses driven by the display encoders and reconstructs the 16-bit hex value being shown. Each pattern must hold for a programmable number of sampled cycles before it is accepted. Each accepted value is decoded per digit and checked for a +1 step against the previous accepted value. The block sits beside the counter/display path as an on-chip self-check and readback monitor.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical enabled samples needed to accept a pattern; legal range 1..255

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_en  input  1  sample qualifier; when low, the block neither samples nor advances the stability count
hex0  input  [0:6]  digit 0 (value bits 3:0) segment bus; active-low; index 0 = seg a ... index 6 = seg g
hex1  input  [0:6]  digit 1 (value bits 7:4)
hex2  input  [0:6]  digit 2 (value bits 11:8)
hex3  input  [0:6]  digit 3 (value bits 15:12)
value  output  16  last accepted decoded value, nibble per digit
dig_valid  output  4  per digit: the accepted pattern was a legal 0-9 glyph
dig_blank  output  4  per digit: the accepted pattern was 7'b1111111
seg_err  output  1  at least one accepted digit pattern is neither a legal glyph nor blank
update  output  1  one-cycle pulse when a new value is published
step_chk  output  1  one-cycle pulse, coincident with update, when a step check was performed
step_ok  output  1  one-cycle pulse, coincident with step_chk, when the check passed
step_err_cnt  output  8  saturating count of failed step checks

Behaviour:
- Reset is synchronous and takes priority over all other inputs. It clears value, dig_valid, dig_blank, seg_err, update, step_chk, step_ok and step_err_cnt to 0. It sets the candidate register cand to all ones, clears the stability count cnt to 0, and clears the published flag pub to 0.
- Glyph table, bus order a..g, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001101, 8 = 0000000, 9 = 0000100
  - Blank = 1111111.
- Per-digit decode:
  - Legal glyph: nibble = digit value, valid = 1, blank = 0.
  - Blank: nibble = 0, valid = 0, blank = 1.
  - Any other pattern: nibble = 0, valid = 0, blank = 0, and the digit is counted as illegal.
- Stability tracking, on each edge with sample_en = 1. Let S = {hex3, hex2, hex1, hex0}.
  - If S == cand: cnt = min(cnt + 1, STABLE_CYCLES).
  - Otherwise: cand = S and cnt = 1.
- With sample_en = 0, cand and cnt hold.
- Acceptance: occurs on the edge where cnt transitions from a value below STABLE_CYCLES to exactly STABLE_CYCLES. With STABLE_CYCLES = 1, every differing sample is accepted on its own edge.
- Publish: on an acceptance edge, publish if pub == 0 or the accepted vector differs from the last published vector.
  - Publishing registers value, dig_valid, dig_blank and seg_err from the decode of S.
  - update = 1 for that cycle; pub is set to 1.
  - Accepting a vector identical to the last published one produces no update. This covers a glitch that returns to the displayed value.
- Latency: outputs change on the same edge as the STABLE_CYCLES-th consecutive identical enabled sample.
- Step check: performed on a publish when pub was already 1 and dig_valid == 4'hF for both the previous and the new published value.
  - step_chk = 1.
  - step_ok = 1 if new == (old + 1) mod 2^16; comparison is on 16-bit hex, so 0x0009 -> 0x000A is never checked because A blanks.
  - On a failed check, step_err_cnt increments and saturates at 255.
  - No check is made if either value contains a blank or illegal digit.
- update, step_chk and step_ok are low on every non-publish cycle.
- Reset mid-stabilization discards all progress; a full STABLE_CYCLES run is needed afterwards.

Test Plan:
1. Reset, then hold digits 1,2,3,4 (hex3..hex0) with sample_en = 1 -> update on the 4th sampling edge, value = 0x1234, dig_valid = 4'hF, step_chk = 0.
2. Change hex0 to 5 -> update 4 edges later, value = 0x1235, step_chk = 1, step_ok = 1, step_err_cnt = 0.
3. Change hex0 to 7 -> value = 0x1237, step_chk = 1, step_ok = 0, step_err_cnt = 1. Repeat 300 bad steps -> step_err_cnt saturates at 255.
4. From 0x1237, show 8 for 2 edges then return to 7 -> no update at any point. Show 8 for 4 edges -> update, value = 0x1238, step_ok = 1.
5. Set hex0 = 1111111 -> dig_blank = 4'b0001, dig_valid = 4'b1110, no step_chk. Then set hex0 = 1111110 -> seg_err = 1, dig_blank = 0.
6. Drop sample_en for 10 cycles after 2 identical samples -> no update; update after 2 more enabled samples. Assert reset when cnt = 3 -> all outputs 0, and the next update needs 4 fresh samples. With STABLE_CYCLES = 1 -> update on the first differing sample.
